// File: rtl/irq_ctrl.sv
// Machine-level interrupt controller: samples CLINT timer/software and one external line,
// gates with mie/mstatus.MIE and holds a frozen-cause request until ack/mret. Option: IRQ_CTRL_EXT_SYNC_EN.
module irq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            i_timer_int_call,
    input  logic            i_software_int_call,
    input  logic            i_external_int_call,
    input  logic [XLEN-1:0] i_mie,
    input  logic            i_mstatus_mie,
    input  logic            i_ack,
    input  logic            i_mret,
    output logic            o_irq,
    output logic [XLEN-1:0] o_cause,
    output logic [XLEN-1:0] o_mip,
    output logic            o_in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_mip;
    logic [XLEN-1:0] r_cause;
    logic            r_irq;
    logic            r_in_service;

    logic            w_ext;
    logic [XLEN-1:0] w_mip_next;
    logic [XLEN-1:0] w_en;
    logic            w_fire;
    logic [3:0]      w_code;
    logic [XLEN-1:0] w_cause;

`ifdef IRQ_CTRL_EXT_SYNC_EN
    // External line may be asynchronous to clk: two-flop synchronizer ahead of mip.
    logic [1:0] r_ext_sync;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_ext_sync <= 2'b00;
        end else begin
            r_ext_sync <= {r_ext_sync[0], i_external_int_call};
        end
    end

    assign w_ext = r_ext_sync[1];
`else
    assign w_ext = i_external_int_call;
`endif

    always_comb begin
        w_mip_next     = '0;
        w_mip_next[3]  = i_software_int_call;
        w_mip_next[7]  = i_timer_int_call;
        w_mip_next[11] = w_ext;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_mip <= '0;
        end else begin
            r_mip <= w_mip_next;
        end
    end

    // r_mip only ever has bits 3/7/11 set, so the full AND yields just those enables.
    assign w_en   = r_mip & i_mie;
    assign w_fire = i_mstatus_mie & (|w_en);

    always_comb begin
        if (w_en[11]) begin
            w_code = 4'd11;
        end else if (w_en[3]) begin
            w_code = 4'd3;
        end else begin
            w_code = 4'd7;
        end
    end

    assign w_cause = {1'b1, {(XLEN-5){1'b0}}, w_code};

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state      <= IDLE;
            r_irq        <= 1'b0;
            r_cause      <= '0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_cause <= w_cause;
                        r_irq   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    // Request is held with its cause frozen; only ack moves it on.
                    if (i_ack) begin
                        r_irq        <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (i_mret) begin
                        r_in_service <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_irq        <= 1'b0;
                    r_in_service <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign o_irq        = r_irq;
    assign o_cause      = r_cause;
    assign o_mip        = r_mip;
    assign o_in_service = r_in_service;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Machine-level interrupt controller directly downstream of the CLINT.
- Samples the CLINT timer and software interrupt calls plus one external interrupt line.
- Applies mie/mstatus.MIE gating and fixed RISC-V priority, then issues a held request with a frozen mcause value to the core's trap logic.
- Tracks the trap through ack and mret; nesting is not supported.

Parameters:
- XLEN, 32, width of the mcause and mip outputs.

Ports:
- clk  input  1  system clock.
- arst  input  1  reset.
- i_timer_int_call  input  1  CLINT timer interrupt, level.
- i_software_int_call  input  1  CLINT software interrupt, level.
- i_external_int_call  input  1  external interrupt, level.
- i_mie  input  XLEN  mie CSR; bits 3 (MSIE), 7 (MTIE) and 11 (MEIE) are used.
- i_mstatus_mie  input  1  global machine interrupt enable.
- i_ack  input  1  core has entered the trap, one-cycle pulse.
- i_mret  input  1  core executed mret, one-cycle pulse.
- o_irq  output  1  interrupt request to the core.
- o_cause  output  XLEN  mcause value for the request.
- o_mip  output  XLEN  sampled pending bits for mip CSR reads.
- o_in_service  output  1  a trap is being serviced.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. The port is named arst; arst=0 resets the block.
- Reset values: state=IDLE; o_irq=0; o_cause=0; o_mip=0; o_in_service=0.
- Pending register (mip):
  - Registered every cycle, 1-cycle latency from the inputs.
  - mip[3]=software, mip[7]=timer, mip[11]=external; all other bits 0.
  - o_mip drives the register directly.
- Enabled set: en = mip & i_mie, bits 3, 7 and 11 only. fire = i_mstatus_mie & (en != 0).
- Priority, highest first: external (code 11) > software (code 3) > timer (code 7).
- Cause encoding: o_cause = {1'b1, (XLEN-5) zeros, 4-bit code}. Example for XLEN=32: timer = 0x80000007.
- State IDLE:
  - If fire, register the cause of the highest-priority enabled bit and go to REQ.
  - o_irq=1 from the next cycle.
- State REQ:
  - o_irq=1.
  - o_cause is frozen, even if a higher-priority source arrives or all sources drop. The request is never withdrawn.
  - i_ack=1: go to SERVICE; o_irq=0 and o_in_service=1 from the next cycle.
  - i_mstatus_mie dropping while in REQ has no effect.
- State SERVICE:
  - o_irq=0; new pending sources are ignored for request purposes, but mip still updates.
  - i_mret=1: go to IDLE. If fire holds in that same cycle, a new request is raised no earlier than the following cycle (IDLE evaluates it).
- Out-of-state pulses:
  - i_ack outside REQ is ignored.
  - i_mret outside SERVICE is ignored.
  - i_ack and i_mret together in REQ: ack wins; mret is ignored.
- Minimum latency: input edge -> mip (1 cycle) -> o_irq (1 cycle) = 2 cycles.
- o_cause holds its last value in SERVICE and IDLE. It is only updated on the IDLE->REQ transition.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values; a pending trap is lost.

Optional Feature:
- Macro: IRQ_CTRL_EXT_SYNC_EN.
- Defined:
  - i_external_int_call passes through a 2-flop synchronizer, reset to 0, before the mip register.
  - External latency to o_irq becomes 4 cycles.
  - Timer and software paths are unchanged.
- Undefined: the external input feeds mip directly, with 2-cycle latency like the others.

Test Plan:
1. Reset with timer=1 and mie[7]=1 applied -> o_irq=0, o_mip=0 while arst=0. After release, o_mip=0x80 and o_irq=1 two cycles after release, o_cause=0x80000007.
2. Timer, software and external all asserted in the same cycle, mie=0x888, mstatus_mie=1 -> o_cause=0x8000000B. After ack and mret with external dropped, the next request has o_cause=0x80000003.
3. Timer pending with i_mstatus_mie=0 -> o_irq stays 0 and o_mip[7]=1. Raise mstatus_mie -> o_irq=1 one cycle later.
4. REQ with timer cause, then timer deasserted before ack -> o_irq stays 1 and o_cause stays 0x80000007 until i_ack. Next cycle o_irq=0, o_in_service=1.
5. SERVICE with software pending -> no o_irq. i_mret -> IDLE, then o_irq=1 with o_cause=0x80000003. i_ack issued in IDLE has no effect.
6. arst pulsed low while in REQ -> o_irq, o_cause and o_in_service are 0 immediately. With IRQ_CTRL_EXT_SYNC_EN defined, an external edge yields o_irq exactly 4 cycles later.
